// File: rtl/pipe_pkg.sv
// Shared types and default widths for the flow-controlled pipeline stage registers.
// The bundle struct below is the default-width layout; parametrised stages build their own.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned RADDR_W_DEF = 3;
  localparam int unsigned IMM_W_DEF   = 5;
  localparam int unsigned ALUC_W_DEF  = 4;

  typedef struct packed {
    logic regwrite;
    logic write_data_control;
    logic cbwrite;
    logic memwrite;
    logic memread;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Control bits that must read 0 on a bubble; they change architectural state downstream.
  localparam ctrl_t CTRL_INERT_MASK = '{
    regwrite:           1'b1,
    write_data_control: 1'b0,
    cbwrite:            1'b1,
    memwrite:           1'b1,
    memread:            1'b1
  };

  typedef struct packed {
    ctrl_t                   ctrl;
    logic [ALUC_W_DEF-1:0]   alucontrol;
    logic [DATA_W_DEF-1:0]   rs_data;
    logic [DATA_W_DEF-1:0]   rt_data;
    logic [RADDR_W_DEF-1:0]  rs_addr;
    logic [RADDR_W_DEF-1:0]  rt_addr;
    logic [RADDR_W_DEF-1:0]  write_addr;
    logic [IMM_W_DEF-1:0]    immediate;
  } idex_bundle_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  function automatic ctrl_t ctrl_make_inert(input ctrl_t c);
    return ctrl_t'(c & ~CTRL_INERT_MASK);
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid register for an opaque payload of width W.
// Bits set in CLR_MASK are zeroed in storage on every transition to EMPTY.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned    W        = 8,
  parameter logic [W-1:0]   CLR_MASK = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_data_o,
  output logic [1:0]    occupancy_o
);

  skid_state_e  state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         out_valid_q;
  logic         in_ready_q;
  logic [1:0]   occ_q;

  logic accept;
  logic drain;

  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else if (flush_i) begin
      // A drain in this cycle has already been taken by the consumer; nothing to keep.
      state_q     <= SKID_EMPTY;
      main_q      <= main_q & ~CLR_MASK;
      skid_q      <= skid_q & ~CLR_MASK;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            main_q      <= in_data_i;
            state_q     <= SKID_ONE;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            main_q <= in_data_i;
          end else if (accept) begin
            skid_q     <= in_data_i;
            state_q    <= SKID_FULL;
            in_ready_q <= 1'b0;
            occ_q      <= 2'd2;
          end else if (drain) begin
            main_q      <= main_q & ~CLR_MASK;
            state_q     <= SKID_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= SKID_ONE;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd1;
          end
        end
        default: begin
          state_q     <= SKID_EMPTY;
          main_q      <= main_q & ~CLR_MASK;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          occ_q       <= 2'd0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign occupancy_o = occ_q;

endmodule

// File: rtl/pipeline_idex_skid.sv
// ID/EX stage register with valid/ready flow control, flush and inert bubbles.
// Splits the decoded bundle into a flat payload for pipe_skid_reg and merges it back.
module pipeline_idex_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF,
  parameter int unsigned IMM_W   = IMM_W_DEF,
  parameter int unsigned ALUC_W  = ALUC_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ALUC_W-1:0]  alucontrol_i,
  input  logic               regwrite_i,
  input  logic               write_data_control_i,
  input  logic               CBwrite_i,
  input  logic               memwrite_i,
  input  logic               memread_i,
  input  logic [DATA_W-1:0]  rs_data_i,
  input  logic [DATA_W-1:0]  rt_data_i,
  input  logic [RADDR_W-1:0] rs_addr_i,
  input  logic [RADDR_W-1:0] rt_addr_i,
  input  logic [RADDR_W-1:0] write_addr_i,
  input  logic [IMM_W-1:0]   immediate_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ALUC_W-1:0]  alucontrol_o,
  output logic               regwrite_o,
  output logic               write_data_control_o,
  output logic               CBwrite_o,
  output logic               memwrite_o,
  output logic               memread_o,
  output logic [DATA_W-1:0]  rs_data_o,
  output logic [DATA_W-1:0]  rt_data_o,
  output logic [RADDR_W-1:0] rs_addr_o,
  output logic [RADDR_W-1:0] rt_addr_o,
  output logic [RADDR_W-1:0] write_addr_o,
  output logic [IMM_W-1:0]   immediate_o,
  output logic [1:0]         occupancy_o
);

  typedef struct packed {
    ctrl_t               ctrl;
    logic [ALUC_W-1:0]   alucontrol;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [RADDR_W-1:0]  rs_addr;
    logic [RADDR_W-1:0]  rt_addr;
    logic [RADDR_W-1:0]  write_addr;
    logic [IMM_W-1:0]    immediate;
  } bundle_t;

  localparam int unsigned BW = $bits(bundle_t);

  // ctrl is the MSB field, so the clear mask is the inert mask followed by zeros.
  localparam logic [BW-1:0] CLR_MASK = {CTRL_INERT_MASK, {(BW - CTRL_W){1'b0}}};

  bundle_t         in_b;
  bundle_t         out_b;
  logic [BW-1:0]   out_data;
  logic            out_valid;
  ctrl_t           ctrl_view;

  always_comb begin
    in_b                         = '0;
    in_b.ctrl.regwrite           = regwrite_i;
    in_b.ctrl.write_data_control = write_data_control_i;
    in_b.ctrl.cbwrite            = CBwrite_i;
    in_b.ctrl.memwrite           = memwrite_i;
    in_b.ctrl.memread            = memread_i;
    in_b.alucontrol              = alucontrol_i;
    in_b.rs_data                 = rs_data_i;
    in_b.rt_data                 = rt_data_i;
    in_b.rs_addr                 = rs_addr_i;
    in_b.rt_addr                 = rt_addr_i;
    in_b.write_addr              = write_addr_i;
    in_b.immediate               = immediate_i;
  end

  pipe_skid_reg #(
    .W        (BW),
    .CLR_MASK (CLR_MASK)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data),
    .occupancy_o (occupancy_o)
  );

  assign out_b = bundle_t'(out_data);

  // Storage is already cleared on entry to EMPTY; gating by valid is a second guarantee.
  assign ctrl_view = out_valid ? out_b.ctrl : ctrl_make_inert(out_b.ctrl);

  assign out_valid_o          = out_valid;
  assign regwrite_o           = ctrl_view.regwrite;
  assign write_data_control_o = ctrl_view.write_data_control;
  assign CBwrite_o            = ctrl_view.cbwrite;
  assign memwrite_o           = ctrl_view.memwrite;
  assign memread_o            = ctrl_view.memread;
  assign alucontrol_o         = out_b.alucontrol;
  assign rs_data_o            = out_b.rs_data;
  assign rt_data_o            = out_b.rt_data;
  assign rs_addr_o            = out_b.rs_addr;
  assign rt_addr_o            = out_b.rt_addr;
  assign write_addr_o         = out_b.write_addr;
  assign immediate_o          = out_b.immediate;

endmodule

// File: tb/tb_pipeline_idex_skid.sv
// Directed bench for pipeline_idex_skid: queue scoreboard of accepted bundles,
// popped and compared whenever EX drains; occupancy modelled as queue depth.
module tb_pipeline_idex_skid;

  localparam int BW = 5 + 4 + 8 + 8 + 3 + 3 + 3 + 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] aluc_i;
  logic       regwrite_i, wdc_i, cbwrite_i, memwrite_i, memread_i;
  logic [7:0] rs_data_i, rt_data_i;
  logic [2:0] rs_addr_i, rt_addr_i, waddr_i;
  logic [4:0] imm_i;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] aluc_o;
  logic       regwrite_o, wdc_o, cbwrite_o, memwrite_o, memread_o;
  logic [7:0] rs_data_o, rt_data_o;
  logic [2:0] rs_addr_o, rt_addr_o, waddr_o;
  logic [4:0] imm_o;
  logic [1:0] occ;

  pipeline_idex_skid dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alucontrol_i(aluc_i), .regwrite_i(regwrite_i), .write_data_control_i(wdc_i),
    .CBwrite_i(cbwrite_i), .memwrite_i(memwrite_i), .memread_i(memread_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .rs_addr_i(rs_addr_i),
    .rt_addr_i(rt_addr_i), .write_addr_i(waddr_i), .immediate_i(imm_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alucontrol_o(aluc_o), .regwrite_o(regwrite_o), .write_data_control_o(wdc_o),
    .CBwrite_o(cbwrite_o), .memwrite_o(memwrite_o), .memread_o(memread_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .rs_addr_o(rs_addr_o),
    .rt_addr_o(rt_addr_o), .write_addr_o(waddr_o), .immediate_o(imm_o),
    .occupancy_o(occ)
  );

  logic        w_in_valid, w_in_ready, w_out_valid;
  logic [15:0] w_rt_i, w_rt_o, w_rs_o;
  logic [7:0]  w_imm_i, w_imm_o;
  logic [3:0]  w_aluc_o;
  logic        w_rw_o, w_wdc_o, w_cb_o, w_mw_o, w_mr_o;
  logic [2:0]  w_rsa_o, w_rta_o, w_wa_o;
  logic [1:0]  w_occ;

  pipeline_idex_skid #(.DATA_W(16), .RADDR_W(3), .IMM_W(8), .ALUC_W(4)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .alucontrol_i(4'h3), .regwrite_i(1'b1), .write_data_control_i(1'b0),
    .CBwrite_i(1'b0), .memwrite_i(1'b0), .memread_i(1'b1),
    .rs_data_i(16'h1234), .rt_data_i(w_rt_i), .rs_addr_i(3'd1),
    .rt_addr_i(3'd2), .write_addr_i(3'd3), .immediate_i(w_imm_i),
    .out_valid_o(w_out_valid), .out_ready_i(1'b1),
    .alucontrol_o(w_aluc_o), .regwrite_o(w_rw_o), .write_data_control_o(w_wdc_o),
    .CBwrite_o(w_cb_o), .memwrite_o(w_mw_o), .memread_o(w_mr_o),
    .rs_data_o(w_rs_o), .rt_data_o(w_rt_o), .rs_addr_o(w_rsa_o),
    .rt_addr_o(w_rta_o), .write_addr_o(w_wa_o), .immediate_o(w_imm_o),
    .occupancy_o(w_occ)
  );

  logic [BW-1:0] sb[$];
  int checks = 0;
  int errors = 0;
  bit last_acc;

  function automatic logic [BW-1:0] in_vec();
    return {regwrite_i, wdc_i, cbwrite_i, memwrite_i, memread_i, aluc_i,
            rs_data_i, rt_data_i, rs_addr_i, rt_addr_i, waddr_i, imm_i};
  endfunction

  function automatic logic [BW-1:0] out_vec();
    return {regwrite_o, wdc_o, cbwrite_o, memwrite_o, memread_o, aluc_o,
            rs_data_o, rt_data_o, rs_addr_o, rt_addr_o, waddr_o, imm_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] rs);
    {regwrite_i, wdc_i, cbwrite_i, memwrite_i, memread_i} = 5'($urandom);
    aluc_i    = 4'($urandom);
    rs_data_i = rs;
    rt_data_i = 8'($urandom);
    rs_addr_i = 3'($urandom);
    rt_addr_i = 3'($urandom);
    waddr_i   = 3'($urandom);
    imm_i     = 5'($urandom);
  endtask

  // Checks handshake state against the model, then advances one clock edge.
  task automatic tick();
    bit acc, drn;
    int depth;
    logic [BW-1:0] exp;
    depth = sb.size();
    acc = in_valid && (depth != 2);
    drn = (depth != 0) && out_ready;
    chk("in_ready", 64'(in_ready), 64'(depth != 2));
    chk("out_valid", 64'(out_valid), 64'(depth != 0));
    chk("occupancy", 64'(occ), 64'(depth));
    if (drn) begin
      exp = sb.pop_front();
      chk("bundle", 64'(out_vec()), 64'(exp));
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(in_vec());
    last_acc = acc && !flush;
    @(posedge clk);
    #1;
    if (sb.size() == 0)
      chk("inert_ctrl", 64'({regwrite_o, cbwrite_o, memwrite_o, memread_o}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(8'h00);
    w_in_valid = 1'b0; w_rt_i = '0; w_imm_i = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_occ", 64'(occ), 64'(0));
    chk("rst_outputs", 64'(out_vec()), 64'(0));
    chk("rst_w_occ", 64'(w_occ), 64'(0));
    rst_n = 1'b1;

    // streaming at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(8'(8'h10 + i));
      tick();
      chk("stream_rs", 64'(rs_data_o), 64'(8'h10 + i));
      chk("stream_occ", 64'(occ), 64'(1));
    end
    in_valid = 1'b0;
    tick();

    // back-pressure: A and B fill, C waits at ID
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(8'h21); tick();
    chk("bp_occ1", 64'(occ), 64'(1));
    drive(8'h22); tick();
    chk("bp_occ2", 64'(occ), 64'(2));
    chk("bp_ready0", 64'(in_ready), 64'(0));
    drive(8'h23); tick();
    chk("bp_c_held", 64'(last_acc), 64'(0));
    out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      if (last_acc) break;
    end
    chk("bp_c_accepted", 64'(last_acc), 64'(1));
    in_valid = 1'b0;
    tick(); tick();
    chk("bp_drained", 64'(occ), 64'(0));

    // flush while FULL with an accept attempted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(8'h31); {regwrite_i, cbwrite_i, memwrite_i, memread_i} = 4'hF; tick();
    drive(8'h32); {regwrite_i, cbwrite_i, memwrite_i, memread_i} = 4'hF; tick();
    chk("fl_full", 64'(occ), 64'(2));
    drive(8'h33); {regwrite_i, cbwrite_i, memwrite_i, memread_i} = 4'hF;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_occ", 64'(occ), 64'(0));
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_ctrl", 64'({regwrite_o, memwrite_o, memread_o, cbwrite_o}), 64'(0));
    out_ready = 1'b1;
    tick(); tick();

    // flush in ONE while EX drains: the drained bundle counts, the incoming one is lost
    in_valid = 1'b1;
    drive(8'h41); tick();
    drive(8'h42); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    drive(8'h43); tick();
    chk("post_flush_rs", 64'(rs_data_o), 64'(8'h43));
    in_valid = 1'b0;
    tick();

    // bubbles after a store drains
    in_valid = 1'b1;
    drive(8'h51); memwrite_i = 1'b1; tick();
    chk("store_mw", 64'(memwrite_o), 64'(1));
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_mw", 64'(memwrite_o), 64'(0));
      chk("bubble_valid", 64'(out_valid), 64'(0));
    end

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(8'h61); tick();
    drive(8'h62); tick();
    drive(8'h63);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_ready", 64'(in_ready), 64'(1));
    chk("mrst_occ", 64'(occ), 64'(0));
    chk("mrst_outputs", 64'(out_vec()), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // wide-parameter instance
    w_rt_i = 16'hBEEF; w_imm_i = 8'hA5; w_in_valid = 1'b1;
    @(posedge clk);
    #1;
    w_in_valid = 1'b0;
    chk("w_valid", 64'(w_out_valid), 64'(1));
    chk("w_rt", 64'(w_rt_o), 64'(16'hBEEF));
    chk("w_imm", 64'(w_imm_o), 64'(8'hA5));
    chk("w_rs", 64'(w_rs_o), 64'(16'h1234));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
